// File: rtl/simd_fetch_sched_if.sv
// simd_fetch_sched_if: request, RAM read port and neighbourhood output bundle of the fetch scheduler.
interface simd_fetch_sched_if #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 19
);
   logic [15:0]           cfg_width;
   logic [15:0]           cfg_height;
   logic                  req_valid;
   logic                  req_ready;
   logic [16*LANES-1:0]   req_x0;
   logic [15:0]           req_y0;
   logic                  mem_re;
   logic [ADDR_W-1:0]     mem_addr;
   logic [7:0]            mem_data_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [32*LANES-1:0]   out_pix;
   logic                  busy;
   logic                  err_oob;

   // Environment side: sequencer, RAM and interpolation lanes
   modport master (
      output cfg_width, cfg_height, req_valid, req_x0, req_y0, mem_data_in, out_ready,
      input  req_ready, mem_re, mem_addr, out_valid, out_pix, busy, err_oob
   );

   // Scheduler side
   modport slave (
      input  cfg_width, cfg_height, req_valid, req_x0, req_y0, mem_data_in, out_ready,
      output req_ready, mem_re, mem_addr, out_valid, out_pix, busy, err_oob
   );
endinterface

// File: rtl/simd_fetch_sched.sv
// simd_fetch_sched: serially fetches the 2x2 source neighbourhood of every SIMD lane
// from the single-port image RAM and hands the whole bundle over with valid/ready.
module simd_fetch_sched #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 19,
   parameter int RD_LAT = 1
) (
   input  logic              clk_i,
   input  logic              aclr_n_i,
   simd_fetch_sched_if.slave bus
);
   localparam int N  = 4 * LANES;
   localparam int CW = $clog2(N + 1);
   localparam int LW = CW - 2;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       iss_cnt_q, cap_cnt_q;
   logic [16*LANES-1:0] xc_q, x1_q, xc_d, x1_d;
   logic [15:0]         yc_q, y1_q, yc_d, y1_d, w_q;
   logic                err_q, err_d;
   logic [32*LANES-1:0] pix_q;
   logic [15:0]         wm1, hm1, xsel, ysel;
   logic                accept, zero_dim, mem_re, last_issue, cap_fire, last_cap;
   logic [RD_LAT:0]     vld;

   assign accept     = (state_q == IDLE) && bus.req_valid;
   assign zero_dim   = (bus.cfg_width == 16'd0) || (bus.cfg_height == 16'd0);
   assign wm1        = bus.cfg_width - 16'd1;
   assign hm1        = bus.cfg_height - 16'd1;
   assign mem_re     = (state_q == ISSUE);
   assign last_issue = mem_re && (iss_cnt_q == CW'(N - 1));
   assign cap_fire   = vld[RD_LAT];
   assign last_cap   = cap_fire && (cap_cnt_q == CW'(N - 1));

   // Read-valid pipeline: bit k is set when the read issued k cycles ago is due now
   assign vld[0] = mem_re;
   generate
      if (RD_LAT > 0) begin : g_pipe
         logic [RD_LAT-1:0] vld_q;
         // Shift issued-read markers along so capture lines up with RAM latency
         always_ff @(posedge clk_i or negedge aclr_n_i) begin
            if (!aclr_n_i) vld_q <= '0;
            else           vld_q <= vld[RD_LAT-1:0];
         end
         assign vld[RD_LAT:1] = vld_q;
      end
   endgenerate

   // Clamp incoming coordinates with edge replication and flag anything out of range
   always_comb begin
      xc_d  = '0;
      x1_d  = '0;
      err_d = zero_dim;
      yc_d  = (bus.req_y0 >= bus.cfg_height) ? hm1 : bus.req_y0;
      y1_d  = (yc_d < hm1) ? yc_d + 16'd1 : yc_d;
      if (bus.req_y0 >= bus.cfg_height) err_d = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         if (bus.req_x0[16*i +: 16] >= bus.cfg_width) begin
            xc_d[16*i +: 16] = wm1;
            err_d            = 1'b1;
         end else begin
            xc_d[16*i +: 16] = bus.req_x0[16*i +: 16];
         end
         x1_d[16*i +: 16] = (xc_d[16*i +: 16] < wm1) ? xc_d[16*i +: 16] + 16'd1
                                                      : xc_d[16*i +: 16];
      end
   end

   // Pick the pixel for the current issue slot: lane = count/4, bit0 = x+1, bit1 = y+1
   always_comb begin
      xsel = '0;
      ysel = iss_cnt_q[1] ? y1_q : yc_q;
      for (int i = 0; i < LANES; i++) begin
         if (iss_cnt_q[CW-1:2] == LW'(i)) begin
            xsel = iss_cnt_q[0] ? x1_q[16*i +: 16] : xc_q[16*i +: 16];
         end
      end
   end

   // Next-state logic; zero-sized images skip straight to the output handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req_valid) state_d = zero_dim ? OUT : ISSUE;
         ISSUE:   if (last_issue) state_d = (RD_LAT == 0) ? OUT : DRAIN;
         DRAIN:   if (last_cap) state_d = OUT;
         OUT:     if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge aclr_n_i) begin
      if (!aclr_n_i) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Latch the request at accept, then step issue and capture counters independently
   always_ff @(posedge clk_i or negedge aclr_n_i) begin
      if (!aclr_n_i) begin
         xc_q      <= '0;
         x1_q      <= '0;
         yc_q      <= '0;
         y1_q      <= '0;
         w_q       <= '0;
         err_q     <= 1'b0;
         pix_q     <= '0;
         iss_cnt_q <= '0;
         cap_cnt_q <= '0;
      end else if (accept) begin
         xc_q      <= xc_d;
         x1_q      <= x1_d;
         yc_q      <= yc_d;
         y1_q      <= y1_d;
         w_q       <= bus.cfg_width;
         err_q     <= err_d;
         pix_q     <= '0;
         iss_cnt_q <= '0;
         cap_cnt_q <= '0;
      end else begin
         if (mem_re) iss_cnt_q <= iss_cnt_q + 1'b1;
         if (cap_fire) begin
            cap_cnt_q <= cap_cnt_q + 1'b1;
            for (int k = 0; k < N; k++) begin
               if (cap_cnt_q == CW'(k)) pix_q[8*k +: 8] <= bus.mem_data_in;
            end
         end
      end
   end

   assign bus.mem_re    = mem_re;
   assign bus.mem_addr  = mem_re ? ADDR_W'({16'd0, ysel} * {16'd0, w_q} + {16'd0, xsel}) : '0;
   assign bus.req_ready = (state_q == IDLE);
   assign bus.out_valid = (state_q == OUT);
   assign bus.out_pix   = pix_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.err_oob   = err_q;
endmodule

// File: tb/tb_simd_fetch_sched.sv
// tb_simd_fetch_sched: directed checks of the fetch scheduler at RD_LAT 0, 1 and 3
// against an 8x4 image RAM holding mem[y*8+x] = (y+1)*16 + x.
module tb_simd_fetch_sched;
   localparam int LANES  = 4;
   localparam int ADDR_W = 19;
   localparam logic [127:0] PIX_BASIC = 128'h27261716_25241514_23221312_21201110;
   localparam logic [127:0] PIX_CLAMP = {16{8'h47}};
   localparam logic [127:0] PIX_OOB   = 128'h37362726_35342524_37372727_31302120;
   localparam logic [63:0]  X_BASIC   = {16'd6, 16'd4, 16'd2, 16'd0};
   localparam logic [63:0]  X_CLAMP   = {16'd7, 16'd7, 16'd7, 16'd7};
   localparam logic [63:0]  X_OOB     = {16'd6, 16'd4, 16'd9, 16'd0};

   logic        clk = 1'b0;
   logic        aclr_n = 1'b0;
   logic [15:0] cfg_w, cfg_h, y0;
   logic [63:0] x0;
   logic        req_v, out_rdy;
   int          sel;
   logic [7:0]  ram [256];
   logic [7:0]  rd1, rd3a, rd3b, rd3c;

   int          n_checks = 0;
   int          n_pass = 0;
   int          n_re, first_valid;
   logic [ADDR_W-1:0] addr_log [64];

   logic              obs_re, obs_valid, obs_rdy, obs_busy, obs_err;
   logic [ADDR_W-1:0] obs_addr;
   logic [127:0]      obs_pix;

   always #5 clk = ~clk;

   simd_fetch_sched_if #(.LANES(LANES), .ADDR_W(ADDR_W)) bus0 ();
   simd_fetch_sched_if #(.LANES(LANES), .ADDR_W(ADDR_W)) bus1 ();
   simd_fetch_sched_if #(.LANES(LANES), .ADDR_W(ADDR_W)) bus3 ();

   assign bus0.cfg_width = cfg_w;  assign bus0.cfg_height = cfg_h;
   assign bus0.req_x0    = x0;     assign bus0.req_y0     = y0;
   assign bus0.req_valid = req_v && (sel == 0);
   assign bus0.out_ready = out_rdy;
   assign bus0.mem_data_in = ram[bus0.mem_addr[7:0]];

   assign bus1.cfg_width = cfg_w;  assign bus1.cfg_height = cfg_h;
   assign bus1.req_x0    = x0;     assign bus1.req_y0     = y0;
   assign bus1.req_valid = req_v && (sel == 1);
   assign bus1.out_ready = out_rdy;
   assign bus1.mem_data_in = rd1;

   assign bus3.cfg_width = cfg_w;  assign bus3.cfg_height = cfg_h;
   assign bus3.req_x0    = x0;     assign bus3.req_y0     = y0;
   assign bus3.req_valid = req_v && (sel == 3);
   assign bus3.out_ready = out_rdy;
   assign bus3.mem_data_in = rd3c;

   // One-cycle registered RAM
   always_ff @(posedge clk) rd1 <= ram[bus1.mem_addr[7:0]];

   // Three-cycle pipelined RAM
   always_ff @(posedge clk) begin
      rd3a <= ram[bus3.mem_addr[7:0]];
      rd3b <= rd3a;
      rd3c <= rd3b;
   end

   simd_fetch_sched #(.LANES(LANES), .ADDR_W(ADDR_W), .RD_LAT(0)) dut0 (
      .clk_i(clk), .aclr_n_i(aclr_n), .bus(bus0.slave));
   simd_fetch_sched #(.LANES(LANES), .ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (
      .clk_i(clk), .aclr_n_i(aclr_n), .bus(bus1.slave));
   simd_fetch_sched #(.LANES(LANES), .ADDR_W(ADDR_W), .RD_LAT(3)) dut3 (
      .clk_i(clk), .aclr_n_i(aclr_n), .bus(bus3.slave));

   // Route the outputs of the scheduler under test to a common set of observation signals
   always_comb begin
      obs_re = bus1.mem_re;     obs_addr = bus1.mem_addr;   obs_valid = bus1.out_valid;
      obs_pix = bus1.out_pix;   obs_rdy = bus1.req_ready;   obs_busy = bus1.busy;
      obs_err = bus1.err_oob;
      case (sel)
         0: begin
            obs_re = bus0.mem_re;     obs_addr = bus0.mem_addr;   obs_valid = bus0.out_valid;
            obs_pix = bus0.out_pix;   obs_rdy = bus0.req_ready;   obs_busy = bus0.busy;
            obs_err = bus0.err_oob;
         end
         3: begin
            obs_re = bus3.mem_re;     obs_addr = bus3.mem_addr;   obs_valid = bus3.out_valid;
            obs_pix = bus3.out_pix;   obs_rdy = bus3.req_ready;   obs_busy = bus3.busy;
            obs_err = bus3.err_oob;
         end
         default: ;
      endcase
   end

   // Present a request across one edge, then log reads until out_valid or timeout.
   // Cycle 0 is the cycle right after the accept edge.
   task automatic do_request(input logic [63:0] xv, input logic [15:0] yv,
                             input logic [15:0] wv, input logic [15:0] hv);
      cfg_w = wv; cfg_h = hv; x0 = xv; y0 = yv; req_v = 1'b1;
      @(posedge clk); #1;
      req_v = 1'b0;
      n_re = 0;
      first_valid = -1;
      for (int c = 0; c < 60; c++) begin
         if (obs_valid) begin
            first_valid = c;
            break;
         end
         if (obs_re) begin
            if (n_re < 64) addr_log[n_re] = obs_addr;
            n_re++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic release_out();
      out_rdy = 1'b1;
      @(posedge clk); #1;
      out_rdy = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (obs_rdy !== 1'b1) $display("[TB] FAIL reset req_ready: got %b expected 1", obs_rdy); else n_pass++;
      n_checks++; if (obs_re !== 1'b0) $display("[TB] FAIL reset mem_re: got %b expected 0", obs_re); else n_pass++;
      n_checks++; if (obs_addr !== '0) $display("[TB] FAIL reset mem_addr: got %h expected 0", obs_addr); else n_pass++;
      n_checks++; if (obs_valid !== 1'b0) $display("[TB] FAIL reset out_valid: got %b expected 0", obs_valid); else n_pass++;
      n_checks++; if (obs_pix !== '0) $display("[TB] FAIL reset out_pix: got %h expected 0", obs_pix); else n_pass++;
      n_checks++; if (obs_busy !== 1'b0) $display("[TB] FAIL reset busy: got %b expected 0", obs_busy); else n_pass++;
      n_checks++; if (obs_err !== 1'b0) $display("[TB] FAIL reset err_oob: got %b expected 0", obs_err); else n_pass++;
   endtask

   task automatic test_basic();
      int exp_addr [16] = '{0, 1, 8, 9, 2, 3, 10, 11, 4, 5, 12, 13, 6, 7, 14, 15};
      sel = 1;
      do_request(X_BASIC, 16'd0, 16'd8, 16'd4);
      n_checks++; if (n_re !== 16) $display("[TB] FAIL basic read count: got %0d expected 16", n_re); else n_pass++;
      n_checks++; if (first_valid !== 17) $display("[TB] FAIL basic valid cycle: got %0d expected 17", first_valid); else n_pass++;
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (addr_log[i] !== ADDR_W'(exp_addr[i]))
            $display("[TB] FAIL basic addr[%0d]: got %0d expected %0d", i, addr_log[i], exp_addr[i]);
         else n_pass++;
      end
      n_checks++; if (obs_pix !== PIX_BASIC) $display("[TB] FAIL basic out_pix: got %h expected %h", obs_pix, PIX_BASIC); else n_pass++;
      n_checks++; if (obs_err !== 1'b0) $display("[TB] FAIL basic err_oob: got %b expected 0", obs_err); else n_pass++;
      n_checks++; if (obs_busy !== 1'b1) $display("[TB] FAIL basic busy: got %b expected 1", obs_busy); else n_pass++;
      release_out();
   endtask

   task automatic test_backpressure();
      sel = 1;
      do_request(X_BASIC, 16'd0, 16'd8, 16'd4);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++; if (obs_pix !== PIX_BASIC) $display("[TB] FAIL hold out_pix: got %h expected %h", obs_pix, PIX_BASIC); else n_pass++;
         n_checks++; if (obs_valid !== 1'b1) $display("[TB] FAIL hold out_valid: got %b expected 1", obs_valid); else n_pass++;
         n_checks++; if (obs_re !== 1'b0) $display("[TB] FAIL hold mem_re: got %b expected 0", obs_re); else n_pass++;
         n_checks++; if (obs_rdy !== 1'b0) $display("[TB] FAIL hold req_ready: got %b expected 0", obs_rdy); else n_pass++;
      end
      out_rdy = 1'b1;
      #1;
      n_checks++; if (obs_rdy !== 1'b0) $display("[TB] FAIL handshake req_ready: got %b expected 0", obs_rdy); else n_pass++;
      @(posedge clk); #1;
      out_rdy = 1'b0;
      n_checks++; if (obs_rdy !== 1'b1) $display("[TB] FAIL after pop req_ready: got %b expected 1", obs_rdy); else n_pass++;
      n_checks++; if (obs_valid !== 1'b0) $display("[TB] FAIL after pop out_valid: got %b expected 0", obs_valid); else n_pass++;
      n_checks++; if (obs_busy !== 1'b0) $display("[TB] FAIL after pop busy: got %b expected 0", obs_busy); else n_pass++;
   endtask

   task automatic test_edge_clamp();
      sel = 1;
      do_request(X_CLAMP, 16'd3, 16'd8, 16'd4);
      n_checks++; if (obs_pix !== PIX_CLAMP) $display("[TB] FAIL clamp out_pix: got %h expected %h", obs_pix, PIX_CLAMP); else n_pass++;
      n_checks++; if (obs_err !== 1'b0) $display("[TB] FAIL clamp err_oob: got %b expected 0", obs_err); else n_pass++;
      release_out();
      do_request(X_OOB, 16'd1, 16'd8, 16'd4);
      n_checks++; if (obs_pix !== PIX_OOB) $display("[TB] FAIL oob out_pix: got %h expected %h", obs_pix, PIX_OOB); else n_pass++;
      n_checks++; if (obs_err !== 1'b1) $display("[TB] FAIL oob err_oob: got %b expected 1", obs_err); else n_pass++;
      release_out();
      n_checks++; if (obs_err !== 1'b1) $display("[TB] FAIL oob sticky err_oob: got %b expected 1", obs_err); else n_pass++;
      do_request(X_BASIC, 16'd0, 16'd8, 16'd4);
      n_checks++; if (obs_err !== 1'b0) $display("[TB] FAIL err clear err_oob: got %b expected 0", obs_err); else n_pass++;
      release_out();
   endtask

   task automatic test_reset_mid_issue();
      sel = 1;
      cfg_w = 16'd8; cfg_h = 16'd4; x0 = X_OOB; y0 = 16'd1; req_v = 1'b1;
      @(posedge clk); #1;
      req_v = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      aclr_n = 1'b0;
      #1;
      test_reset();
      #2;
      aclr_n = 1'b1;
      @(posedge clk); #1;
      do_request(X_BASIC, 16'd0, 16'd8, 16'd4);
      n_checks++; if (first_valid !== 17) $display("[TB] FAIL post-reset valid cycle: got %0d expected 17", first_valid); else n_pass++;
      n_checks++; if (obs_pix !== PIX_BASIC) $display("[TB] FAIL post-reset out_pix: got %h expected %h", obs_pix, PIX_BASIC); else n_pass++;
      n_checks++; if (obs_err !== 1'b0) $display("[TB] FAIL post-reset err_oob: got %b expected 0", obs_err); else n_pass++;
      release_out();
   endtask

   task automatic test_zero_dim();
      sel = 1;
      do_request(X_BASIC, 16'd0, 16'd0, 16'd4);
      n_checks++; if (n_re !== 0) $display("[TB] FAIL zero read count: got %0d expected 0", n_re); else n_pass++;
      n_checks++; if (first_valid !== 0) $display("[TB] FAIL zero valid cycle: got %0d expected 0", first_valid); else n_pass++;
      n_checks++; if (obs_pix !== '0) $display("[TB] FAIL zero out_pix: got %h expected 0", obs_pix); else n_pass++;
      n_checks++; if (obs_err !== 1'b1) $display("[TB] FAIL zero err_oob: got %b expected 1", obs_err); else n_pass++;
      release_out();
   endtask

   task automatic test_rd_lat();
      sel = 0;
      do_request(X_BASIC, 16'd0, 16'd8, 16'd4);
      n_checks++; if (n_re !== 16) $display("[TB] FAIL lat0 read count: got %0d expected 16", n_re); else n_pass++;
      n_checks++; if (first_valid !== 16) $display("[TB] FAIL lat0 valid cycle: got %0d expected 16", first_valid); else n_pass++;
      n_checks++; if (obs_pix !== PIX_BASIC) $display("[TB] FAIL lat0 out_pix: got %h expected %h", obs_pix, PIX_BASIC); else n_pass++;
      release_out();
      sel = 3;
      do_request(X_BASIC, 16'd0, 16'd8, 16'd4);
      n_checks++; if (n_re !== 16) $display("[TB] FAIL lat3 read count: got %0d expected 16", n_re); else n_pass++;
      n_checks++; if (first_valid !== 19) $display("[TB] FAIL lat3 valid cycle: got %0d expected 19", first_valid); else n_pass++;
      n_checks++; if (obs_pix !== PIX_BASIC) $display("[TB] FAIL lat3 out_pix: got %h expected %h", obs_pix, PIX_BASIC); else n_pass++;
      release_out();
      sel = 1;
   endtask

   initial begin
      for (int a = 0; a < 256; a++) ram[a] = (a < 32) ? 8'(((a / 8) + 1) * 16 + (a % 8)) : 8'hEE;
      cfg_w = 16'd0; cfg_h = 16'd0; x0 = '0; y0 = '0;
      req_v = 1'b0; out_rdy = 1'b0; sel = 1;
      aclr_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      aclr_n = 1'b1;
      @(posedge clk); #1;
      test_basic();
      test_backpressure();
      test_edge_clamp();
      test_reset_mid_issue();
      test_zero_dim();
      test_rd_lat();
      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
